// File: rtl/h4_platform_io.sv
// Board I/O shim for the HD44780 LCD design: button conditioning, alive blink, dimmed RGB pads, parked LEDs/LCD bus.
// Latency: button SYNC_STAGES edges, PWM strobes 1 edge, RGB gating combinational, LCD bus constant.
// Backpressure: none; free-running outputs with no flow control.
//
// Ports:
//   i_clk, i_rst_n     system clock, asynchronous active-low reset
//   i_button_n         raw button pad, active low (pull-up: idle reads 1)
//   i_rgb_en/i_curr_en RGB driver enables; either low forces all RGB pads off
//   i_led_r_req/_b_req requests for red/blue to be lit (dimmed)
//   o_button           synchronised active-high button
//   o_alive            undimmed alive blink level
//   o_rgb_{g,b,r}      RGB pads, active low (current sink)
//   o_led              status LEDs, active low, parked off
//   o_lcd_rs/e/data    LCD bus, parked idle
module h4_platform_io #(
   parameter int         BLINK_BITS    = 25,
   parameter int         PWM_BITS      = 3,
   parameter int         SYNC_STAGES   = 2,
   parameter logic [3:0] LCD_IDLE_DATA = 4'b1010
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_button_n,
   input  logic       i_rgb_en,
   input  logic       i_curr_en,
   input  logic       i_led_r_req,
   input  logic       i_led_b_req,
   output logic       o_button,
   output logic       o_alive,
   output logic       o_rgb_g,
   output logic       o_rgb_b,
   output logic       o_rgb_r,
   output logic [3:0] o_led,
   output logic       o_lcd_rs,
   output logic       o_lcd_e,
   output logic [3:0] o_lcd_data
);

   logic [BLINK_BITS-1:0]  blink_ctr;
   logic [PWM_BITS-1:0]    pwm_ctr;
   logic                   pwm_tick;
   logic                   g_pwm;
   logic                   r_pwm;
   logic                   b_pwm;
   logic [SYNC_STAGES-1:0] sync_chain;
   logic [3:0]             led_q;
   logic                   drv_en;

   // Single-clock strobe once per PWM period: the last count before wrap.
   assign pwm_tick = &pwm_ctr;

   // Alive is high during the first half of each blink period, so it starts
   // lit straight out of reset.
   assign o_alive = ~blink_ctr[BLINK_BITS-1];

   // Counters and PWM strobes. Reset re-aligns blink and PWM phase together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         blink_ctr <= '0;
         pwm_ctr   <= '0;
         g_pwm     <= 1'b0;
         r_pwm     <= 1'b0;
         b_pwm     <= 1'b0;
      end else begin
         blink_ctr <= blink_ctr + BLINK_BITS'(1);
         pwm_ctr   <= pwm_ctr + PWM_BITS'(1);
         g_pwm     <= pwm_tick & o_alive;
         r_pwm     <= pwm_tick & i_led_r_req;
         b_pwm     <= pwm_tick & i_led_b_req;
      end
   end

   // Button synchroniser. Resets to the released (pulled-up) level so the
   // conditioned button reads not-pressed until the pad is actually sampled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_chain <= '1;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], i_button_n};
      end
   end

   assign o_button = ~sync_chain[SYNC_STAGES-1];

   // Status LEDs held off through a register so the pads come from a flop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         led_q <= 4'hF;
      end else begin
         led_q <= 4'hF;
      end
   end

   assign o_led = led_q;

   // RGB driver gate: enables act in the same cycle, pads sink current when low.
   assign drv_en  = i_rgb_en & i_curr_en;
   assign o_rgb_g = ~(drv_en & g_pwm);
   assign o_rgb_r = ~(drv_en & r_pwm);
   assign o_rgb_b = ~(drv_en & b_pwm);

   // LCD bus parked idle; deliberately independent of reset.
   assign o_lcd_rs   = 1'b0;
   assign o_lcd_e    = 1'b0;
   assign o_lcd_data = LCD_IDLE_DATA;

endmodule

// File: tb/tb_h4_platform_io.sv
module tb_h4_platform_io;

   logic       clk;
   logic       rst_n;
   logic       button_n;
   logic       rgb_en;
   logic       curr_en;
   logic       r_req;
   logic       b_req;
   logic       button;
   logic       alive;
   logic       rgb_g;
   logic       rgb_b;
   logic       rgb_r;
   logic [3:0] led;
   logic       lcd_rs;
   logic       lcd_e;
   logic [3:0] lcd_data;

   int checks = 0;
   int errors = 0;

   // Reference model state: edges since reset and expected PWM strobes.
   int   n    = 0;
   logic g_m  = 1'b0;
   logic r_m  = 1'b0;
   logic b_m  = 1'b0;

   h4_platform_io #(
      .BLINK_BITS   (5),
      .PWM_BITS     (3),
      .SYNC_STAGES  (2),
      .LCD_IDLE_DATA(4'b1010)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_button_n (button_n),
      .i_rgb_en   (rgb_en),
      .i_curr_en  (curr_en),
      .i_led_r_req(r_req),
      .i_led_b_req(b_req),
      .o_button   (button),
      .o_alive    (alive),
      .o_rgb_g    (rgb_g),
      .o_rgb_b    (rgb_b),
      .o_rgb_r    (rgb_r),
      .o_led      (led),
      .o_lcd_rs   (lcd_rs),
      .o_lcd_e    (lcd_e),
      .o_lcd_data (lcd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (n=%0d, t=%0t)", nm, act, exp, n, $time);
      end
   endtask

   function automatic logic alive_at(input int k);
      return ((k % 32) < 16);
   endfunction

   task automatic model_reset();
      n   = 0;
      g_m = 1'b0;
      r_m = 1'b0;
      b_m = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rgb_r"}, {3'b0, rgb_r}, 4'h1);
      check({tag, "_rgb_g"}, {3'b0, rgb_g}, 4'h1);
      check({tag, "_rgb_b"}, {3'b0, rgb_b}, 4'h1);
      check({tag, "_button"}, {3'b0, button}, 4'h0);
      check({tag, "_alive"}, {3'b0, alive}, 4'h1);
      check({tag, "_led"}, led, 4'hF);
      check({tag, "_lcd_rs"}, {3'b0, lcd_rs}, 4'h0);
      check({tag, "_lcd_e"}, {3'b0, lcd_e}, 4'h0);
      check({tag, "_lcd_data"}, lcd_data, 4'b1010);
   endtask

   // One clock: advance the model on the same edge, then compare at edge+1.
   task automatic step();
      logic tick;
      logic rq;
      logic bq;
      logic al;
      tick = ((n % 8) == 7);
      rq   = r_req;
      bq   = b_req;
      al   = alive_at(n);
      @(posedge clk);
      #1;
      n++;
      g_m = tick & al;
      r_m = tick & rq;
      b_m = tick & bq;
      check("alive", {3'b0, alive}, {3'b0, alive_at(n)});
      check("rgb_g", {3'b0, rgb_g}, {3'b0, ~(rgb_en & curr_en & g_m)});
      check("rgb_r", {3'b0, rgb_r}, {3'b0, ~(rgb_en & curr_en & r_m)});
      check("rgb_b", {3'b0, rgb_b}, {3'b0, ~(rgb_en & curr_en & b_m)});
   endtask

   typedef struct {
      int   n;
      logic alive;
      logic g;
   } blink_vec_t;

   typedef struct {
      logic rgb_en;
      logic curr_en;
      logic exp_r;
      logic exp_b;
   } gate_vec_t;

   blink_vec_t blink_tbl[13];
   gate_vec_t  gate_tbl[5];

   initial begin
      int idx;
      int g_lows;
      int r_lows;
      int b_lows;
      bit found;

      // Hand-computed: green strobes land at n=8 and n=16 of each 32-clock
      // period (sampled one edge earlier while alive was still high).
      blink_tbl[0]  = '{8,  1'b1, 1'b0};
      blink_tbl[1]  = '{9,  1'b1, 1'b1};
      blink_tbl[2]  = '{15, 1'b1, 1'b1};
      blink_tbl[3]  = '{16, 1'b0, 1'b0};
      blink_tbl[4]  = '{17, 1'b0, 1'b1};
      blink_tbl[5]  = '{24, 1'b0, 1'b1};
      blink_tbl[6]  = '{31, 1'b0, 1'b1};
      blink_tbl[7]  = '{32, 1'b1, 1'b1};
      blink_tbl[8]  = '{40, 1'b1, 1'b0};
      blink_tbl[9]  = '{48, 1'b0, 1'b0};
      blink_tbl[10] = '{56, 1'b0, 1'b1};
      blink_tbl[11] = '{63, 1'b0, 1'b1};
      blink_tbl[12] = '{64, 1'b1, 1'b1};

      // Both strobes active: gating acts in the same cycle.
      gate_tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
      gate_tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
      gate_tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1};
      gate_tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1};
      gate_tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

      rst_n    = 1'b0;
      button_n = 1'b1;
      rgb_en   = 1'b1;
      curr_en  = 1'b1;
      r_req    = 1'b0;
      b_req    = 1'b0;
      model_reset();

      // Reset held across edges.
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("rst");

      // Release mid-cycle; first edge after is n=1.
      #2;
      rst_n = 1'b1;
      #1;
      check("n0_alive", {3'b0, alive}, 4'h1);
      check("n0_rgb_g", {3'b0, rgb_g}, 4'h1);

      // 64-clock alive/green run with hand-computed checkpoints.
      idx    = 0;
      g_lows = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (rgb_g == 1'b0) g_lows++;
         if (idx < 13 && blink_tbl[idx].n == n) begin
            check("tbl_alive", {3'b0, alive}, {3'b0, blink_tbl[idx].alive});
            check("tbl_rgb_g", {3'b0, rgb_g}, {3'b0, blink_tbl[idx].g});
            idx++;
         end
      end
      check("tbl_all_hit", 4'(idx), 4'(13));
      check("g_low_count", 4'(g_lows), 4'(4));

      // Button press/release through the two-stage synchroniser.
      button_n = 1'b0;
      step();
      check("btn_press_e1", {3'b0, button}, 4'h0);
      step();
      check("btn_press_e2", {3'b0, button}, 4'h1);
      button_n = 1'b1;
      step();
      check("btn_rel_e1", {3'b0, button}, 4'h1);
      step();
      check("btn_rel_e2", {3'b0, button}, 4'h0);

      // Red requested, blue not: red low one clock in eight.
      r_req  = 1'b1;
      r_lows = 0;
      b_lows = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (rgb_r == 1'b0) r_lows++;
         if (rgb_b == 1'b0) b_lows++;
      end
      check("r_low_count", 4'(r_lows), 4'(2));
      check("b_low_count", 4'(b_lows), 4'(0));

      // Find a cycle with both strobes active, then sweep the gating table.
      b_req = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 9 && !found; i++) begin
         step();
         if (r_m && b_m) found = 1'b1;
      end
      check("gate_strobe_found", {3'b0, found}, 4'h1);
      if (found) begin
         for (int i = 0; i < 5; i++) begin
            rgb_en  = gate_tbl[i].rgb_en;
            curr_en = gate_tbl[i].curr_en;
            #1;
            check("gate_r", {3'b0, rgb_r}, {3'b0, gate_tbl[i].exp_r});
            check("gate_b", {3'b0, rgb_b}, {3'b0, gate_tbl[i].exp_b});
            check("gate_g", {3'b0, rgb_g}, {3'b0, ~(rgb_en & curr_en & g_m)});
         end
      end
      rgb_en  = 1'b1;
      curr_en = 1'b1;
      r_req   = 1'b0;
      b_req   = 1'b0;

      // Re-align with a fresh reset, run to clock 20, then reset mid-cycle.
      step();
      rst_n = 1'b0;
      #1;
      model_reset();
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check("pre_async_alive", {3'b0, alive}, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async");
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 15; i++) step();
      check("post_rst_n15_alive", {3'b0, alive}, 4'h1);
      step();
      check("post_rst_n16_alive", {3'b0, alive}, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
